// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- generic pipeline stage register with a 2-entry skid buffer.
//
// Carries one packed bundle per beat between two pipeline stages using a
// valid/ready handshake. It sustains full throughput, and in_ready is registered,
// so it has no combinational path from out_ready. flush discards all held beats
// and any beat offered in the same cycle.
//
// Optional feature: define PIPE_STAGE_STATS_EN to enable the saturating
// stall counter. When it is undefined, stall_cnt is tied to 0.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   flush      in   synchronous flush (bubble insertion)
//   in_valid   in   upstream beat present
//   in_ready   out  stage can accept a beat (registered)
//   in_data    in   upstream bundle [DATA_W]
//   out_valid  out  beat available downstream
//   out_ready  in   downstream accepts (low = stall)
//   out_data   out  bundle to downstream [DATA_W]
//   occupancy  out  beats held: 0, 1 or 2
//   stall_cnt  out  stall cycle counter [CNT_W]
module pipe_stage_reg #(
    parameter int unsigned          DATA_W    = 64,
    parameter logic [DATA_W-1:0]    RESET_VAL = {DATA_W{1'b0}},
    parameter int unsigned          CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q;
    logic              accept, pop;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != StEmpty);
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d = StOne;
                        main_d  = in_data;
                    end
                end
                StOne: begin
                    if (accept && pop) begin
                        main_d = in_data;
                    end else if (accept) begin
                        state_d = StTwo;
                        skid_d  = in_data;
                    end else if (pop) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    // in_ready is low here, so only a pop can happen; the skid
                    // beat is older than anything upstream and moves to main.
                    if (pop) begin
                        state_d = StOne;
                        main_d  = skid_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_comb begin
        occupancy = 2'd0;
        unique case (state_q)
            StEmpty: occupancy = 2'd0;
            StOne:   occupancy = 2'd1;
            StTwo:   occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            main_q     <= RESET_VAL;
            skid_q     <= RESET_VAL;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            // Registered copy of !skid_valid for the next cycle.
            in_ready_q <= (state_d != StTwo);
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && !flush && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
